kamacore_dmem_responder: RTL and testbench



---
 rtl/kamacore_dmem_responder_pkg.sv | 25 ++
 rtl/kamacore_dmem_responder_if.sv | 29 ++
 rtl/kamacore_dmem_bank.sv | 30 +++
 rtl/kamacore_dmem_responder.sv | 117 +++++++++++
 tb/tb_kamacore_dmem_responder.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/kamacore_dmem_responder_pkg.sv
// rtl/kamacore_dmem_responder_pkg.sv - shared types for the data-memory responder
// Contents: CPU_WIDTH, request/response structs, responder FSM state enum.
package kamacore_dmem_responder_pkg;

    localparam int CPU_WIDTH = 32;

    typedef struct packed {
        logic                   we;
        logic [CPU_WIDTH-1:0]   addr;
        logic [CPU_WIDTH-1:0]   wdata;
        logic [3:0]             be;
    } dmem_req_t;

    typedef struct packed {
        logic [CPU_WIDTH-1:0]   rdata;
        logic                   err;
    } dmem_rsp_t;

    typedef enum logic [1:0] {
        DMEM_IDLE,
        DMEM_WAIT,
        DMEM_RESP
    } dmem_state_e;

endpackage

// File: rtl/kamacore_dmem_responder_if.sv
// rtl/kamacore_dmem_responder_if.sv - data-memory request/response channel
// Request side:  req_valid/req_ready handshake carrying we, addr, wdata, be.
// Response side: rsp_valid/rsp_ready handshake carrying rdata, err.
// master = requester (MEM stage), slave = responder.
interface kamacore_dmem_responder_if;
    import kamacore_dmem_responder_pkg::*;

    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [CPU_WIDTH-1:0]   req_addr;
    logic [CPU_WIDTH-1:0]   req_wdata;
    logic [3:0]             req_be;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [CPU_WIDTH-1:0]   rsp_rdata;
    logic                   rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/kamacore_dmem_bank.sv
// rtl/kamacore_dmem_bank.sv - byte-enabled word array, synchronous write, asynchronous read
// Ports: clk; we write strobe; be[3:0] byte enables; a word index; di write data;
//        spo read data of word a (combinational).
module kamacore_dmem_bank #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] a,
    input  logic [31:0]   di,
    output logic [31:0]   spo
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[a][8*i +: 8] <= di[8*i +: 8];
                end
            end
        end
    end

    assign spo = mem[a];

endmodule

// File: rtl/kamacore_dmem_responder.sv
// rtl/kamacore_dmem_responder.sv - multi-cycle data-memory responder for the MEM stage
// Ports: clk; rst synchronous active-high reset; bus slave side of the
//        request/response channel (see kamacore_dmem_responder_if).
// One request at a time: IDLE accepts, WAIT burns WAIT_CYCLES-1 more cycles,
// RESP performs the access on its first edge and then holds the response
// until the requester takes it.
module kamacore_dmem_responder
    import kamacore_dmem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    kamacore_dmem_responder_if.slave   bus
);

    localparam int AW    = $clog2(DEPTH_WORDS);
    // Counter only has to hold WAIT_CYCLES-1.
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    dmem_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    dmem_req_t          req_q;
    logic               rsp_valid_q;
    dmem_rsp_t          rsp_q;

    logic               accept;
    logic               access;
    logic               fault;
    logic [29:0]        word_off;
    logic [31:0]        bank_rdata;
    logic               bank_we;

    // req_ready depends on state only; it is forced low while rst is high.
    assign bus.req_ready = (state_q == DMEM_IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    // First cycle in RESP is the access cycle; rsp_valid rises on its edge.
    assign access        = (state_q == DMEM_RESP) && !rsp_valid_q;

    // BASE_ADDR is word aligned, so the word offset is a 30-bit subtraction.
    assign word_off = req_q.addr[31:2] - BASE_ADDR[31:2];
    assign fault    = (req_q.addr[1:0] != 2'b00)
                   || (req_q.addr < BASE_ADDR)
                   || (word_off >= 30'(DEPTH_WORDS));

    assign bank_we = access && req_q.we && !fault && !rst;

    kamacore_dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_bank (
        .clk (clk),
        .we  (bank_we),
        .be  (req_q.be),
        .a   (word_off[AW-1:0]),
        .di  (req_q.wdata),
        .spo (bank_rdata)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            DMEM_IDLE: begin
                if (accept) begin
                    state_d = (WAIT_CYCLES == 0) ? DMEM_RESP : DMEM_WAIT;
                end
            end
            DMEM_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DMEM_RESP;
                end
            end
            DMEM_RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    state_d = DMEM_IDLE;
                end
            end
            default: state_d = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DMEM_IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_q.we    <= bus.req_we;
                req_q.addr  <= bus.req_addr;
                req_q.wdata <= bus.req_wdata;
                req_q.be    <= bus.req_be;
                cnt_q       <= CNT_W'(WAIT_CYCLES - 1);
            end
            if (state_q == DMEM_WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (access) begin
                rsp_valid_q <= 1'b1;
                rsp_q.err   <= fault;
                rsp_q.rdata <= (fault || req_q.we) ? 32'h0 : bank_rdata;
            end else if (rsp_valid_q && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_q.rdata;
    assign bus.rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_kamacore_dmem_responder.sv
// tb/tb_kamacore_dmem_responder.sv - self-checking bench for kamacore_dmem_responder
module tb_kamacore_dmem_responder;

    localparam int          DEPTH = 1024;
    localparam int          WAITC = 2;
    localparam logic [31:0] BASE  = 32'h0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    kamacore_dmem_responder_if bus ();
    kamacore_dmem_responder_if bus0 ();

    kamacore_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC), .BASE_ADDR(BASE))
        dut (.clk(clk), .rst(rst), .bus(bus));
    kamacore_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(BASE))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    logic [31:0] model_mem [int unsigned];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_fault(input logic [31:0] addr);
        longint unsigned off;
        off = longint'(addr) - longint'(BASE);
        return (addr % 4 != 0) || (addr < BASE) || (off / 4 >= DEPTH);
    endfunction

    // One transaction on the WAIT_CYCLES=2 responder, checked against the model.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int hold, input string tag);
        int          n;
        logic [31:0] exp_rd, word, rd;
        logic        exp_err, er;
        exp_err = is_fault(addr);
        exp_rd  = 32'h0;
        if (!exp_err) begin
            word = model_mem.exists(addr) ? model_mem[addr] : 32'h0;
            if (we) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) word[8*i +: 8] = wdata[8*i +: 8];
                model_mem[addr] = word;
            end else begin
                exp_rd = word;
            end
        end
        n = 0;
        while (!bus.req_ready && n < 50) begin @(posedge clk); #1; n++; end
        check({tag, " req_ready idle"}, 32'(bus.req_ready), 32'h1);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
        bus.req_wdata = wdata; bus.req_be = be;
        @(posedge clk); #1;
        // Inputs outside the handshake must be ignored.
        bus.req_valid = 1'b0; bus.req_we = ~we; bus.req_addr = $urandom;
        bus.req_wdata = $urandom; bus.req_be = 4'($urandom);
        if (hold == 0) bus.rsp_ready = 1'b1;
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            check({tag, " req_ready busy"}, 32'(bus.req_ready), 32'h0);
            @(posedge clk); #1; n++;
        end
        check({tag, " latency"}, 32'(n), 32'(WAITC + 1));
        check({tag, " rdata"}, bus.rsp_rdata, exp_rd);
        check({tag, " err"}, 32'(bus.rsp_err), 32'(exp_err));
        if (hold > 0) begin
            rd = bus.rsp_rdata; er = bus.rsp_err;
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                check({tag, " hold stable"},
                      32'(bus.rsp_valid && !bus.req_ready && bus.rsp_rdata == rd && bus.rsp_err == er),
                      32'h1);
            end
            bus.rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check({tag, " back to idle"}, 32'({bus.rsp_valid, bus.req_ready}), 32'h1);
    endtask

    initial begin
        logic [31:0] addrs [9];
        logic [31:0] v;
        int          seen;

        bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0; bus.req_wdata = 0;
        bus.req_be = 0; bus.rsp_ready = 0;
        bus0.req_valid = 0; bus0.req_we = 0; bus0.req_addr = 0; bus0.req_wdata = 0;
        bus0.req_be = 0; bus0.rsp_ready = 0;

        // Reset state
        @(posedge clk); #1;
        check("reset req_ready", 32'(bus.req_ready), 32'h0);
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("reset rsp", {bus.rsp_rdata[30:0], bus.rsp_err}, 32'h0);
        check("reset0 req_ready", 32'(bus0.req_ready), 32'h0);
        rst = 1'b0;
        #1;
        check("post reset req_ready", 32'(bus.req_ready), 32'h1);

        // Known contents for every word the random phase may load
        addrs = '{32'h10, 32'h20, 32'h100, 32'h104, 32'h800, 32'hFFC,
                  32'h102, 32'h1000, 32'hFFFF_FFFC};
        for (int i = 0; i < 6; i++)
            txn(1'b1, addrs[i], (i == 1) ? 32'h0 : $urandom, 4'hF, 0, "init");

        // Full store then load
        txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, "t1 store");
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0, "t1 load");
        // Partial store
        txn(1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 0, "t2 store");
        txn(1'b0, 32'h10, 32'h0, 4'hF, 0, "t2 load");
        // Faults
        txn(1'b0, 32'h12, 32'h0, 4'hF, 0, "t3 misaligned");
        txn(1'b0, 32'(4 * DEPTH), 32'h0, 4'hF, 0, "t3 out of range");
        txn(1'b1, 32'h13, 32'h1111_1111, 4'hF, 0, "t3 bad store");
        txn(1'b0, 32'h10, 32'h0, 4'hF, 0, "t3 reload");
        txn(1'b1, 32'hFFC, 32'h5555_6666, 4'b0000, 0, "no-op store");
        txn(1'b0, 32'hFFC, 32'h0, 4'hF, 0, "last word");
        // Backpressure
        txn(1'b0, 32'h10, 32'h0, 4'hF, 5, "t4 backpressure");

        // Reset while a store sits in WAIT
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h20;
        bus.req_wdata = 32'h1234_5678; bus.req_be = 4'hF;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("t5 in wait", 32'(bus.req_ready), 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t5 reset valid/ready", 32'({bus.rsp_valid, bus.req_ready}), 32'h0);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) seen++;
        end
        check("t5 no response", 32'(seen), 32'h0);
        txn(1'b0, 32'h20, 32'h0, 4'hF, 0, "t5 reload");

        // Randomised mix
        for (int i = 0; i < 30; i++)
            txn(1'($urandom), addrs[$urandom_range(0, 8)], $urandom, 4'($urandom),
                $urandom_range(0, 2), "rand");

        // Zero-wait build, back-to-back attempt held off until IDLE
        v = $urandom;
        bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_addr = 32'h40;
        bus0.req_wdata = v; bus0.req_be = 4'hF;
        @(posedge clk); #1;
        check("t6 accepted", 32'({bus0.rsp_valid, bus0.req_ready}), 32'h0);
        bus0.req_we = 1'b0;
        @(posedge clk); #1;
        check("t6 store rsp", 32'({bus0.rsp_valid, bus0.req_ready, bus0.rsp_err}), 32'h4);
        check("t6 store rdata", bus0.rsp_rdata, 32'h0);
        bus0.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus0.rsp_ready = 1'b0;
        check("t6 idle after hs", 32'({bus0.rsp_valid, bus0.req_ready}), 32'h1);
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        check("t6 load accepted", 32'({bus0.rsp_valid, bus0.req_ready}), 32'h0);
        @(posedge clk); #1;
        check("t6 load valid", 32'(bus0.rsp_valid), 32'h1);
        check("t6 load rdata", bus0.rsp_rdata, v);
        bus0.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus0.rsp_ready = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
        $fatal(1, "timeout");
    end

endmodule
